// File: rtl/ps2_key_fifo.sv
// Keystroke capture between PS2_controller and the LCD writer: edge-detects code-ready,
// filters break codes, tracks shift, and buffers {shift, scan_code} words in a FWFT FIFO.
// Optional shift tracking is enabled by defining PS2_KEY_FIFO_SHIFT_TRACK_EN.
module ps2_key_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          Clock_50,
  input  logic          Reset,
  input  logic [7:0]    PS2_code,
  input  logic          PS2_code_ready,
  input  logic          PS2_make_code,
  input  logic          Key_pop,
  input  logic          Flush,
  output logic          Key_valid,
  output logic [8:0]    Key_data,
  output logic [AW:0]   Key_count,
  output logic          Shift_held,
  output logic          Overflow
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = 9;

  logic          ready_q;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [WW-1:0] mem [DEPTH];

  logic          key_event;
  logic          push_req;
  logic          push_ok;
  logic          pop_ok;
  logic          full;
  logic          wr_en;
  logic [WW-1:0] push_word;
  logic [AW-1:0] wp_nx;
  logic [AW-1:0] rp_nx;
  logic [CW-1:0] cnt_nx;
  logic [WW-1:0] head_nx;
  logic          shift_nx;
  logic          ovf_nx;
`ifdef PS2_KEY_FIFO_SHIFT_TRACK_EN
  logic          is_shift;
`endif

  // Event classification: shift codes update state, other makes become push requests
  always_comb begin
    key_event = PS2_code_ready & ~ready_q;
`ifdef PS2_KEY_FIFO_SHIFT_TRACK_EN
    is_shift  = (PS2_code == 8'h12) || (PS2_code == 8'h59);
    push_req  = key_event & PS2_make_code & ~is_shift;
    push_word = {Shift_held, PS2_code};
    shift_nx  = Shift_held;
    if (key_event && is_shift) begin
      shift_nx = PS2_make_code;
    end
`else
    push_req  = key_event & PS2_make_code;
    push_word = {1'b0, PS2_code};
    shift_nx  = 1'b0;
`endif
  end

  // FIFO next-state; the registered head bypasses the write when it lands on the head slot
  always_comb begin
    full    = (cnt == CW'(DEPTH));
    pop_ok  = Key_pop & (cnt != '0);
    push_ok = push_req & (~full | pop_ok);
    wr_en   = push_ok & ~Flush;
    wp_nx   = push_ok ? AW'(wp + 1'b1) : wp;
    rp_nx   = pop_ok  ? AW'(rp + 1'b1) : rp;
    cnt_nx  = CW'(cnt + CW'(push_ok) - CW'(pop_ok));
    ovf_nx  = Overflow | (push_req & ~push_ok);
    head_nx = '0;
    if (cnt_nx != '0) begin
      head_nx = (push_ok && (rp_nx == wp)) ? push_word : mem[rp_nx];
    end
    if (Flush) begin
      wp_nx   = '0;
      rp_nx   = '0;
      cnt_nx  = '0;
      ovf_nx  = 1'b0;
      head_nx = '0;
    end
  end

  // Storage array carries no reset; only slots below cnt are ever observed
  always_ff @(posedge Clock_50) begin
    if (wr_en) begin
      mem[wp] <= push_word;
    end
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      ready_q    <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      Key_valid  <= 1'b0;
      Key_data   <= '0;
      Shift_held <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      ready_q    <= PS2_code_ready;
      wp         <= wp_nx;
      rp         <= rp_nx;
      cnt        <= cnt_nx;
      Key_valid  <= (cnt_nx != '0);
      Key_data   <= head_nx;
      Shift_held <= shift_nx;
      Overflow   <= ovf_nx;
    end
  end

  assign Key_count = cnt;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed self-checking bench for ps2_key_fifo (DEPTH=16); expectations follow
// PS2_KEY_FIFO_SHIFT_TRACK_EN when it is defined for the build.
module tb_ps2_key_fifo;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] PS2_code;
  logic       PS2_code_ready;
  logic       PS2_make_code;
  logic       Key_pop;
  logic       Flush;
  logic       Key_valid;
  logic [8:0] Key_data;
  logic [4:0] Key_count;
  logic       Shift_held;
  logic       Overflow;

  int checks = 0;
  int errors = 0;

  ps2_key_fifo #(.DEPTH(16)) dut (
    .Clock_50      (clk),
    .Reset         (Reset),
    .PS2_code      (PS2_code),
    .PS2_code_ready(PS2_code_ready),
    .PS2_make_code (PS2_make_code),
    .Key_pop       (Key_pop),
    .Flush         (Flush),
    .Key_valid     (Key_valid),
    .Key_data      (Key_data),
    .Key_count     (Key_count),
    .Shift_held    (Shift_held),
    .Overflow      (Overflow)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One code-ready pulse: high for the event edge, then low for one edge
  task automatic key(input logic [7:0] code, input logic make);
    PS2_code       = code;
    PS2_make_code  = make;
    PS2_code_ready = 1'b1;
    tick();
    PS2_code_ready = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] exp);
    chk(tag, 16'(Key_data), 16'(exp));
    Key_pop = 1'b1;
    tick();
    Key_pop = 1'b0;
  endtask

  initial begin
    Reset          = 1'b1;
    PS2_code       = 8'h00;
    PS2_code_ready = 1'b0;
    PS2_make_code  = 1'b0;
    Key_pop        = 1'b0;
    Flush          = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    chk("rst_valid", 16'(Key_valid), 16'd0);
    chk("rst_count", 16'(Key_count), 16'd0);
    chk("rst_data", 16'(Key_data), 16'h000);
    chk("rst_ovf", 16'(Overflow), 16'd0);
    chk("rst_shift", 16'(Shift_held), 16'd0);

    // Single make, one-cycle latency, then pop while the ready level stays high
    PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    tick();
    chk("one_valid", 16'(Key_valid), 16'd1);
    chk("one_data", 16'(Key_data), 16'h01C);
    chk("one_count", 16'(Key_count), 16'd1);
    Key_pop = 1'b1;
    tick();
    Key_pop = 1'b0;
    chk("one_pop_valid", 16'(Key_valid), 16'd0);
    chk("one_pop_data", 16'(Key_data), 16'h000);
    tick();
    chk("held_level_count", 16'(Key_count), 16'd0);
    PS2_code_ready = 1'b0;
    tick();

    // Shift sequence
    key(8'h12, 1'b1);
`ifdef PS2_KEY_FIFO_SHIFT_TRACK_EN
    chk("shift_set", 16'(Shift_held), 16'd1);
`else
    chk("shift_set", 16'(Shift_held), 16'd0);
`endif
    key(8'h1C, 1'b1);
    key(8'h12, 1'b0);
    chk("shift_clr", 16'(Shift_held), 16'd0);
    key(8'h1C, 1'b1);
`ifdef PS2_KEY_FIFO_SHIFT_TRACK_EN
    chk("shift_count", 16'(Key_count), 16'd2);
    pop_chk("shift_w0", 9'h11C);
    pop_chk("shift_w1", 9'h01C);
`else
    chk("shift_count", 16'(Key_count), 16'd3);
    pop_chk("shift_w0", 9'h012);
    pop_chk("shift_w1", 9'h01C);
    pop_chk("shift_w2", 9'h01C);
`endif
    chk("shift_empty", 16'(Key_valid), 16'd0);

    // Fill to DEPTH, then one more make overflows
    for (int i = 0; i < 16; i++) key(8'(8'h15 + i), 1'b1);
    chk("full_count", 16'(Key_count), 16'd16);
    chk("full_no_ovf", 16'(Overflow), 16'd0);
    key(8'h25, 1'b1);
    chk("ovf_count", 16'(Key_count), 16'd16);
    chk("ovf_flag", 16'(Overflow), 16'd1);
    chk("ovf_head", 16'(Key_data), 16'h015);

    // Full with simultaneous push and pop
    PS2_code = 8'h30; PS2_make_code = 1'b1; PS2_code_ready = 1'b1; Key_pop = 1'b1;
    tick();
    PS2_code_ready = 1'b0; Key_pop = 1'b0;
    chk("fullpp_count", 16'(Key_count), 16'd16);
    chk("fullpp_head", 16'(Key_data), 16'h016);
    chk("fullpp_ovf", 16'(Overflow), 16'd1);
    tick();
    for (int i = 0; i < 15; i++) pop_chk("drain", 9'(9'h016 + i));
    pop_chk("drain_tail", 9'h030);
    chk("drain_valid", 16'(Key_valid), 16'd0);
    chk("drain_ovf_sticky", 16'(Overflow), 16'd1);
    Key_pop = 1'b1;
    tick();
    Key_pop = 1'b0;
    chk("underflow_count", 16'(Key_count), 16'd0);
    chk("underflow_data", 16'(Key_data), 16'h000);

    // 40 keys through a one-deep stream: push+pop in the same cycle, wrapping twice
    key(8'h60, 1'b1);
    chk("stream_first", 16'(Key_data), 16'h060);
    for (int i = 1; i < 40; i++) begin
      PS2_code = 8'(8'h60 + i); PS2_make_code = 1'b1; PS2_code_ready = 1'b1; Key_pop = 1'b1;
      tick();
      PS2_code_ready = 1'b0; Key_pop = 1'b0;
      chk("stream_head", 16'(Key_data), 16'(9'(8'h60 + i)));
      chk("stream_count", 16'(Key_count), 16'd1);
      tick();
    end

    // Flush together with a push
    PS2_code = 8'h33; PS2_make_code = 1'b1; PS2_code_ready = 1'b1; Flush = 1'b1;
    tick();
    PS2_code_ready = 1'b0; Flush = 1'b0;
    chk("flush_count", 16'(Key_count), 16'd0);
    chk("flush_ovf", 16'(Overflow), 16'd0);
    chk("flush_valid", 16'(Key_valid), 16'd0);
    chk("flush_data", 16'(Key_data), 16'h000);
    tick();

    // Flush together with a shift make
    PS2_code = 8'h12; PS2_make_code = 1'b1; PS2_code_ready = 1'b1; Flush = 1'b1;
    tick();
    PS2_code_ready = 1'b0; Flush = 1'b0;
`ifdef PS2_KEY_FIFO_SHIFT_TRACK_EN
    chk("flush_shift", 16'(Shift_held), 16'd1);
`else
    chk("flush_shift", 16'(Shift_held), 16'd0);
`endif
    chk("flush_shift_count", 16'(Key_count), 16'd0);
    tick();

    // Asynchronous reset mid-stream discards buffered keys
    key(8'h41, 1'b1);
    key(8'h42, 1'b1);
    chk("pre_rst_count", 16'(Key_count), 16'd2);
    #3 Reset = 1'b1;
    #2;
    chk("async_rst_count", 16'(Key_count), 16'd0);
    chk("async_rst_valid", 16'(Key_valid), 16'd0);
    chk("async_rst_data", 16'(Key_data), 16'h000);
    chk("async_rst_shift", 16'(Shift_held), 16'd0);
    tick();
    Reset = 1'b0;
    tick();
    key(8'h43, 1'b1);
    chk("post_rst_data", 16'(Key_data), 16'h043);
    chk("post_rst_count", 16'(Key_count), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
